// File: rtl/dcmac_0_axis_pkt_mon_id_arb_if.sv
// Handshake bundle between the per-ID stream sources and the packet-monitor ID arbiter.
// The slave modport is the arbiter's view; the master modport is the sources'/pipeline's view.
interface dcmac_0_axis_pkt_mon_id_arb_if #(
    parameter int unsigned NUM_ID = 6,
    parameter int unsigned ID_W   = 3
);
    logic [NUM_ID-1:0] req_vld;
    logic [NUM_ID-1:0] req_sop;
    logic [NUM_ID-1:0] req_eop;
    logic [NUM_ID-1:0] req_rdy;
    logic              dn_rdy;
    logic              o_vld;
    logic [ID_W-1:0]   o_id;
    logic              o_sop;
    logic              o_eop;
    logic              o_locked;
    logic              timeout_err;
    logic [ID_W-1:0]   timeout_id;

    modport slave (
        input  req_vld, req_sop, req_eop, dn_rdy,
        output req_rdy, o_vld, o_id, o_sop, o_eop, o_locked, timeout_err, timeout_id
    );

    modport master (
        output req_vld, req_sop, req_eop, dn_rdy,
        input  req_rdy, o_vld, o_id, o_sop, o_eop, o_locked, timeout_err, timeout_id
    );
endinterface

// File: rtl/dcmac_0_axis_pkt_mon_id_arb.sv
// Packet-granular round-robin arbiter feeding the packet-monitor segment pipeline.
// A grant is held from sop to eop, or until the stall counter forces a release.
module dcmac_0_axis_pkt_mon_id_arb #(
    parameter int unsigned NUM_ID  = 6,
    parameter int unsigned TIMEOUT = 1024,
    localparam int unsigned ID_W   = (NUM_ID == 1) ? 1 : $clog2(NUM_ID)
) (
    input  logic                         clk,
    input  logic                         rstn,
    dcmac_0_axis_pkt_mon_id_arb_if.slave bus
);

    typedef enum logic {StIdle, StLock} state_e;

    localparam logic [15:0]     StallMax = 16'(TIMEOUT - 1);
    localparam logic [ID_W-1:0] LastRst  = ID_W'(NUM_ID - 1);

    state_e            state_q, state_d;
    logic [ID_W-1:0]   grant_id_q, grant_id_d;
    logic [ID_W-1:0]   last_id_q, last_id_d;
    logic [15:0]       stall_q, stall_d;
    logic              o_vld_q, o_vld_d;
    logic [ID_W-1:0]   o_id_q, o_id_d;
    logic              o_sop_q, o_sop_d;
    logic              o_eop_q, o_eop_d;
    logic              timeout_err_q, timeout_err_d;
    logic [ID_W-1:0]   timeout_id_q, timeout_id_d;

    logic [NUM_ID-1:0] eligible;
    logic              sel_found;
    logic [ID_W-1:0]   sel_id;
    logic [ID_W-1:0]   idx;
    logic              xfer;
    logic [NUM_ID-1:0] rdy;

    // Round-robin search starting just above the last served ID.
    always_comb begin
        eligible  = bus.req_vld & bus.req_sop;
        sel_found = 1'b0;
        sel_id    = '0;
        idx       = '0;
        for (int unsigned off = 1; off <= NUM_ID; off++) begin
            idx = ID_W'((32'(last_id_q) + off) % NUM_ID);
            if (!sel_found && eligible[idx]) begin
                sel_found = 1'b1;
                sel_id    = idx;
            end
        end
    end

    always_comb begin
        rdy = '0;
        if (state_q == StLock) begin
            rdy[grant_id_q] = bus.dn_rdy;
        end
    end

    assign xfer = (state_q == StLock) && bus.req_vld[grant_id_q] && bus.dn_rdy;

    always_comb begin
        state_d       = state_q;
        grant_id_d    = grant_id_q;
        last_id_d     = last_id_q;
        stall_d       = stall_q;
        o_vld_d       = xfer;
        o_id_d        = xfer ? grant_id_q : o_id_q;
        o_sop_d       = xfer && bus.req_sop[grant_id_q];
        o_eop_d       = xfer && bus.req_eop[grant_id_q];
        timeout_err_d = 1'b0;
        timeout_id_d  = timeout_id_q;
        unique case (state_q)
            StIdle: begin
                if (sel_found) begin
                    state_d    = StLock;
                    grant_id_d = sel_id;
                    stall_d    = '0;
                end
            end
            StLock: begin
                // A transfer wins over a timeout landing in the same cycle.
                if (xfer) begin
                    stall_d = '0;
                    if (bus.req_eop[grant_id_q]) begin
                        state_d   = StIdle;
                        last_id_d = grant_id_q;
                    end
                end else if (stall_q == StallMax) begin
                    state_d       = StIdle;
                    last_id_d     = grant_id_q;
                    stall_d       = '0;
                    timeout_err_d = 1'b1;
                    timeout_id_d  = grant_id_q;
                end else begin
                    stall_d = stall_q + 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= StIdle;
            grant_id_q    <= '0;
            last_id_q     <= LastRst;
            stall_q       <= '0;
            o_vld_q       <= 1'b0;
            o_id_q        <= '0;
            o_sop_q       <= 1'b0;
            o_eop_q       <= 1'b0;
            timeout_err_q <= 1'b0;
            timeout_id_q  <= '0;
        end else begin
            state_q       <= state_d;
            grant_id_q    <= grant_id_d;
            last_id_q     <= last_id_d;
            stall_q       <= stall_d;
            o_vld_q       <= o_vld_d;
            o_id_q        <= o_id_d;
            o_sop_q       <= o_sop_d;
            o_eop_q       <= o_eop_d;
            timeout_err_q <= timeout_err_d;
            timeout_id_q  <= timeout_id_d;
        end
    end

    assign bus.req_rdy     = rdy;
    assign bus.o_vld       = o_vld_q;
    assign bus.o_id        = o_id_q;
    assign bus.o_sop       = o_sop_q;
    assign bus.o_eop       = o_eop_q;
    assign bus.o_locked    = (state_q == StLock);
    assign bus.timeout_err = timeout_err_q;
    assign bus.timeout_id  = timeout_id_q;

endmodule

// File: tb/tb_dcmac_0_axis_pkt_mon_id_arb.sv
// Directed bench for the packet-monitor ID arbiter: NUM_ID=6, TIMEOUT=8.
// Inputs change 1 ns after the rising edge; outputs are checked in the same quiet window.
module tb_dcmac_0_axis_pkt_mon_id_arb;

    localparam int unsigned NUM_ID  = 6;
    localparam int unsigned TIMEOUT = 8;
    localparam int unsigned ID_W    = 3;

    logic clk;
    logic rstn;
    int   total;
    int   bad;

    dcmac_0_axis_pkt_mon_id_arb_if #(.NUM_ID(NUM_ID), .ID_W(ID_W)) bus ();

    dcmac_0_axis_pkt_mon_id_arb #(
        .NUM_ID (NUM_ID),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_rdy"}, 32'(bus.req_rdy), 0);
        chk({tag, "_vld"}, 32'(bus.o_vld), 0);
        chk({tag, "_id"}, 32'(bus.o_id), 0);
        chk({tag, "_sop"}, 32'(bus.o_sop), 0);
        chk({tag, "_eop"}, 32'(bus.o_eop), 0);
        chk({tag, "_locked"}, 32'(bus.o_locked), 0);
        chk({tag, "_terr"}, 32'(bus.timeout_err), 0);
        chk({tag, "_tid"}, 32'(bus.timeout_id), 0);
    endtask

    // Expects IDLE on entry; checks the arbitration cycle, every beat and the unlock.
    task automatic run_pkt(input int id, input int nb);
        bus.req_vld[id] = 1'b1;
        bus.req_sop[id] = 1'b1;
        bus.req_eop[id] = (nb == 1);
        bus.dn_rdy      = 1'b1;
        step();
        chk("arb_locked", 32'(bus.o_locked), 1);
        chk("arb_gap", 32'(bus.o_vld), 0);
        chk("grant_rdy", 32'(bus.req_rdy), 32'(1) << id);
        for (int b = 0; b < nb; b++) begin
            bus.req_sop[id] = (b == 0);
            bus.req_eop[id] = (b == nb - 1);
            step();
            chk("beat_vld", 32'(bus.o_vld), 1);
            chk("beat_id", 32'(bus.o_id), 32'(id));
            chk("beat_sop", 32'(bus.o_sop), 32'(b == 0));
            chk("beat_eop", 32'(bus.o_eop), 32'(b == nb - 1));
        end
        chk("pkt_unlock", 32'(bus.o_locked), 0);
        bus.req_vld[id] = 1'b0;
        bus.req_sop[id] = 1'b0;
        bus.req_eop[id] = 1'b0;
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        rstn        = 1'b0;
        bus.req_vld = '0;
        bus.req_sop = '0;
        bus.req_eop = '0;
        bus.dn_rdy  = 1'b0;
        #12;
        chk_zero("reset");
        rstn = 1'b1;

        // Non-sop beat in IDLE is ignored
        bus.req_vld[2] = 1'b1;
        bus.dn_rdy     = 1'b1;
        step();
        chk("nosop_locked", 32'(bus.o_locked), 0);
        chk("nosop_rdy", 32'(bus.req_rdy), 0);
        bus.req_vld = '0;

        // IDs 0, 2, 5 with 3-beat packets: served 0, 2, 5
        bus.req_vld = 6'b100101;
        bus.req_sop = 6'b100101;
        #1;
        chk("idle_rdy", 32'(bus.req_rdy), 0);
        run_pkt(0, 3);
        run_pkt(2, 3);
        run_pkt(5, 3);

        // Single-beat packets from IDs 1 and 4: 1, then 4, then 1 again
        bus.req_vld[4] = 1'b1;
        bus.req_sop[4] = 1'b1;
        bus.req_eop[4] = 1'b1;
        run_pkt(1, 1);
        bus.req_vld[1] = 1'b1;
        bus.req_sop[1] = 1'b1;
        bus.req_eop[1] = 1'b1;
        run_pkt(4, 1);
        run_pkt(1, 1);

        // ID 3 locked, dn_rdy toggled 1,0,0,1
        bus.req_vld[3] = 1'b1;
        bus.req_sop[3] = 1'b1;
        bus.dn_rdy     = 1'b1;
        step();
        chk("t3_locked", 32'(bus.o_locked), 1);
        chk("t3_rdy1", 32'(bus.req_rdy), 32'h08);
        step();
        chk("t3_vld1", 32'(bus.o_vld), 1);
        chk("t3_sop1", 32'(bus.o_sop), 1);
        bus.req_sop[3] = 1'b0;
        bus.dn_rdy     = 1'b0;
        #1;
        chk("t3_rdy0a", 32'(bus.req_rdy), 0);
        step();
        chk("t3_vld0a", 32'(bus.o_vld), 0);
        chk("t3_hold", 32'(bus.o_locked), 1);
        chk("t3_rdy0b", 32'(bus.req_rdy), 0);
        step();
        chk("t3_vld0b", 32'(bus.o_vld), 0);
        bus.dn_rdy     = 1'b1;
        bus.req_eop[3] = 1'b1;
        #1;
        chk("t3_rdy1b", 32'(bus.req_rdy), 32'h08);
        step();
        chk("t3_vld_eop", 32'(bus.o_vld), 1);
        chk("t3_id", 32'(bus.o_id), 3);
        chk("t3_eop", 32'(bus.o_eop), 1);
        chk("t3_unlock", 32'(bus.o_locked), 0);
        bus.req_vld = '0;
        bus.req_sop = '0;
        bus.req_eop = '0;

        // ID 2 stalls after its sop beat: timeout after 8 stall cycles
        bus.req_vld[2] = 1'b1;
        bus.req_sop[2] = 1'b1;
        step();
        chk("to_rdy", 32'(bus.req_rdy), 32'h04);
        step();
        chk("to_sopbeat", 32'(bus.o_vld), 1);
        chk("to_sopid", 32'(bus.o_id), 2);
        bus.req_vld[2] = 1'b0;
        bus.req_sop[2] = 1'b0;
        for (int k = 0; k < 7; k++) begin
            step();
            chk("to_wait_locked", 32'(bus.o_locked), 1);
            chk("to_wait_terr", 32'(bus.timeout_err), 0);
        end
        step();
        chk("to_terr", 32'(bus.timeout_err), 1);
        chk("to_tid", 32'(bus.timeout_id), 2);
        chk("to_unlock", 32'(bus.o_locked), 0);
        chk("to_novld", 32'(bus.o_vld), 0);
        bus.req_vld = 6'b001001;
        bus.req_sop = 6'b001001;
        step();
        chk("to_pulse_end", 32'(bus.timeout_err), 0);
        chk("to_tid_hold", 32'(bus.timeout_id), 2);
        chk("to_next_grant", 32'(bus.req_rdy), 32'h08);
        bus.req_eop[3] = 1'b1;
        step();
        chk("to_next_eop", 32'(bus.o_eop), 1);
        bus.req_vld = '0;
        bus.req_sop = '0;
        bus.req_eop = '0;

        // Transfer exactly at stall count TIMEOUT-1, then the counter restarts
        bus.req_vld[0] = 1'b1;
        bus.req_sop[0] = 1'b1;
        step();
        chk("edge_rdy", 32'(bus.req_rdy), 32'h01);
        bus.dn_rdy = 1'b0;
        for (int k = 0; k < 7; k++) begin
            step();
            chk("edge_wait_locked", 32'(bus.o_locked), 1);
        end
        bus.dn_rdy = 1'b1;
        step();
        chk("edge_vld", 32'(bus.o_vld), 1);
        chk("edge_terr", 32'(bus.timeout_err), 0);
        chk("edge_locked", 32'(bus.o_locked), 1);
        bus.req_sop[0] = 1'b0;
        bus.dn_rdy     = 1'b0;
        for (int k = 0; k < 7; k++) begin
            step();
            chk("edge_clr_locked", 32'(bus.o_locked), 1);
            chk("edge_clr_terr", 32'(bus.timeout_err), 0);
        end
        bus.dn_rdy     = 1'b1;
        bus.req_eop[0] = 1'b1;
        step();
        chk("edge_eop", 32'(bus.o_eop), 1);
        chk("edge_unlock", 32'(bus.o_locked), 0);
        chk("edge_terr2", 32'(bus.timeout_err), 0);
        bus.req_vld = '0;
        bus.req_sop = '0;
        bus.req_eop = '0;

        // Reset mid-packet on ID 4, then ID 0 wins first
        bus.req_vld[4] = 1'b1;
        bus.req_sop[4] = 1'b1;
        step();
        chk("rst_rdy4", 32'(bus.req_rdy), 32'h10);
        step();
        chk("rst_beat_id", 32'(bus.o_id), 4);
        bus.req_sop[4] = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        chk_zero("rst_async");
        bus.req_vld = 6'b010001;
        bus.req_sop = 6'b010001;
        step();
        chk_zero("rst_hold");
        #2;
        rstn = 1'b1;
        step();
        chk("post_rst_vld", 32'(bus.o_vld), 0);
        chk("post_rst_locked", 32'(bus.o_locked), 1);
        chk("post_rst_grant", 32'(bus.req_rdy), 32'h01);
        bus.req_eop[0] = 1'b1;
        step();
        chk("post_rst_beat", 32'(bus.o_id), 0);
        chk("post_rst_eop", 32'(bus.o_eop), 1);
        bus.req_vld = '0;
        bus.req_sop = '0;
        bus.req_eop = '0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dcmac_0_axis_pkt_mon_id_arb.md
DCMAC_0_AXIS_PKT_MON_ID_ARB -- requirements
Module: dcmac_0_axis_pkt_mon_id_arb

Interface
REQ-001: Parameter NUM_ID, default 6, is the number of requesting stream IDs sharing the packet-monitor segment pipeline; legal range 1..16.
REQ-002: Parameter TIMEOUT, default 1024, is the number of stall cycles allowed while locked before the grant is forcibly released; legal range 2..65535.
REQ-003: Localparam ID_W SHALL be 1 when NUM_ID==1, otherwise $clog2(NUM_ID).
REQ-004: clk  in  1  single clock; all logic is rising-edge.
REQ-005: rstn  in  1  asynchronous reset, active-low.
REQ-006: req_vld  in  NUM_ID  per-ID beat-available flag.
REQ-007: req_sop  in  NUM_ID  per-ID start-of-packet qualifier for the presented beat.
REQ-008: req_eop  in  NUM_ID  per-ID end-of-packet qualifier for the presented beat.
REQ-009: req_rdy  out  NUM_ID  per-ID accept; at most one bit set.
REQ-010: dn_rdy  in  1  downstream shift-segment pipeline can accept a beat.
REQ-011: o_vld  out  1  registered beat-transferred strobe.
REQ-012: o_id  out  ID_W  ID of the transferred beat; this drives the pipeline id field.
REQ-013: o_sop / o_eop  out  1 each  qualifiers of the transferred beat.
REQ-014: o_locked  out  1  high while a grant is held.
REQ-015: timeout_err  out  1  one-cycle pulse on a forced release.
REQ-016: timeout_id  out  ID_W  ID that timed out; holds its value until the next timeout.

Function
REQ-017: The FSM SHALL have two states: IDLE and LOCK.
REQ-018: In IDLE, eligible = req_vld & req_sop. Beats without sop SHALL be ignored in IDLE, and req_rdy SHALL be all-zero in IDLE.
REQ-019: In IDLE with any eligible bit set, the block SHALL select the first eligible ID searching round-robin upward from last_id+1, wrapping at NUM_ID-1 to 0.
REQ-020: On that selection the block SHALL register grant_id and enter LOCK on the next edge (one arbitration cycle).
REQ-021: In LOCK, req_rdy[grant_id] SHALL equal dn_rdy combinationally, and all other req_rdy bits SHALL be 0.
REQ-022: A transfer occurs when req_vld[grant_id] & req_rdy[grant_id].
REQ-023: On each transfer, the next cycle SHALL show o_vld=1, o_id=grant_id, o_sop=req_sop[grant_id], o_eop=req_eop[grant_id]. Latency is 1 cycle; without a transfer, o_vld=0, and o_sop/o_eop are 0.
REQ-024: A transfer with req_eop[grant_id]=1 SHALL cause a return to IDLE and set last_id=grant_id. A single-beat packet (sop and eop together) follows the same rule.
REQ-025: A 16-bit stall counter SHALL clear on entry to LOCK and on every transfer, and SHALL increment on every other LOCK cycle.
REQ-026: When the stall counter equals TIMEOUT-1 with no transfer in that cycle, the block SHALL:
- return to IDLE,
- set last_id=grant_id,
- pulse timeout_err for the next cycle,
- load timeout_id=grant_id.
REQ-027: A transfer in the same cycle the counter reaches TIMEOUT-1 SHALL take priority, and no timeout SHALL occur.
REQ-028: Mid-packet sop beats from the granted ID SHALL be passed through unchanged; the block does not check protocol.
REQ-029: o_locked SHALL equal (state==LOCK).
REQ-030: With NUM_ID==1, round-robin degenerates to always selecting ID 0.
REQ-031: Sustained throughput is one packet per (beats+1) cycles per grant; the IDLE cycle between packets is required.

Reset
REQ-032: While rstn=0, the block SHALL hold state=IDLE, last_id=NUM_ID-1 (so ID 0 has first priority), stall counter=0, and grant_id=0.
REQ-033: While rstn=0, the outputs SHALL be: req_rdy=0, o_vld=0, o_id=0, o_sop=0, o_eop=0, o_locked=0, timeout_err=0, timeout_id=0.
REQ-034: Reset asserted mid-packet SHALL abandon the grant immediately, and no further transfer SHALL be reported.
REQ-035: After reset deasserts, arbitration SHALL restart from ID 0 priority.

Verification
REQ-036: Stimulus: after reset, IDs 0, 2 and 5 hold sop beats with dn_rdy=1 and 3-beat packets. Required: grants in order 0, 2, 5; o_id sequence 0,0,0,2,2,2,5,5,5; one idle cycle between packets.
REQ-037: Stimulus: ID 3 is locked and dn_rdy is toggled 1,0,0,1. Required: req_rdy[3] follows dn_rdy; o_vld appears one cycle after each accepted beat; other req_rdy bits stay 0.
REQ-038: Stimulus: ID 1 sends a sop&eop single beat while ID 1 and ID 4 both request. Required: ID 1 is granted first, then ID 4, then ID 1 again (round-robin wrap).
REQ-039: Stimulus: TIMEOUT=8, ID 2 is locked, req_vld[2]=0 after sop. Required: after 8 stall cycles, timeout_err pulses once, timeout_id=2, o_locked=0, and the next grant goes to ID 3 or above.
REQ-040: Stimulus: a transfer occurs exactly at stall count TIMEOUT-1. Required: no timeout_err, and the counter clears.
REQ-041: Stimulus: rstn driven low mid-packet on ID 4. Required: all outputs 0 asynchronously; after release, an ID 0 request is granted first.
